// File: rtl/pps_time_tx.sv
// pps_time_tx
//   Transmit side of the PPS/second timing link. One 35-bit timing frame is
//   serialized per accepted PPS flag. The falling edge of the start bit is the
//   PPS time reference seen by downstream boards.
//
//   Frame (LSB first, each bit held BIT_DIV cycles):
//     start(0) | sec[0] .. sec[31] | parity(^sec) | stop(1)
//
//   Ports
//     sys_clk_i      in   1   system clock
//     sys_rst_n_i    in   1   asynchronous active-low reset
//     en_i           in   1   transmit enable; low = no new frames accepted
//     pps_flag_i     in   1   single-cycle PPS flag
//     cur_sec_i      in  32   second value, latched in the accept cycle
//     ovr_clr_i      in   1   clears overrun_o
//     txd_o          out  1   serial timing line, idles high
//     busy_o         out  1   frame in progress
//     overrun_o      out  1   sticky: PPS arrived while a frame was in flight
//     frame_count_o  out 16   completed frames, wraps
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   S_IDLE   | line high, waiting for an enabled PPS flag
//   S_START  | start bit (0) on the line; its leading edge is the PPS
//   S_DATA   | 32 second bits, LSB first, bit_q = current index
//   S_PARITY | even parity over the captured second
//   S_STOP   | stop bit (1); frame counted on leaving this state
module pps_time_tx #(
  parameter int BIT_DIV = 8
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_n_i,
  input  logic        en_i,
  input  logic        pps_flag_i,
  input  logic [31:0] cur_sec_i,
  input  logic        ovr_clr_i,
  output logic        txd_o,
  output logic        busy_o,
  output logic        overrun_o,
  output logic [15:0] frame_count_o
);

  localparam int DIV_W = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);

  if (BIT_DIV < 2) begin : g_bad_bit_div
    $fatal(1, "pps_time_tx: BIT_DIV must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       bit_q, bit_d;
  logic [31:0]      sh_q, sh_d;
  logic             par_q, par_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;
  logic             ovr_q, ovr_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic bit_end;
  logic accept;
  logic collide;

  assign bit_end = (div_q == DIV_LAST);
  assign accept  = (state_q == S_IDLE) && en_i && pps_flag_i;
  assign collide = (state_q != S_IDLE) && en_i && pps_flag_i;

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      sh_q        <= '0;
      par_q       <= 1'b0;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
      par_q       <= par_d;
      txd_q       <= txd_d;
      busy_q      <= busy_d;
      ovr_q       <= ovr_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    par_d       = par_q;
    txd_d       = txd_q;
    busy_d      = busy_q;
    frame_cnt_d = frame_cnt_q;

    if (state_q != S_IDLE) begin
      div_d = bit_end ? '0 : div_q + 1'b1;
    end

    // txd is registered, so each bit value is loaded on the last divider
    // cycle of the previous bit; the shift register always presents the
    // next data bit in sh_q[0].
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          sh_d    = cur_sec_i;
          par_d   = ^cur_sec_i;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          txd_d   = sh_q[0];
          sh_d    = sh_q >> 1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 5'd31) begin
            state_d = S_PARITY;
            txd_d   = par_q;
          end else begin
            bit_d = bit_q + 5'd1;
            txd_d = sh_q[0];
            sh_d  = sh_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d     = S_IDLE;
          busy_d      = 1'b0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Set wins over clear when both happen in the same cycle.
    if (collide) begin
      ovr_d = 1'b1;
    end else if (ovr_clr_i) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  assign txd_o         = txd_q;
  assign busy_o        = busy_q;
  assign overrun_o     = ovr_q;
  assign frame_count_o = frame_cnt_q;

endmodule

// File: tb/tb_pps_time_tx.sv
// tb_pps_time_tx
//   Self-checking bench for pps_time_tx with BIT_DIV=4. A monitor decodes
//   every frame seen on txd_o and compares it against seconds queued when
//   each PPS was driven; the scenario tasks check timing, overrun, enable,
//   reset and counter behaviour directly.
module tb_pps_time_tx;

  localparam int BD = 4;
  localparam int FL = 35 * BD;

  logic        sys_clk_i = 1'b0;
  logic        sys_rst_n_i;
  logic        en_i;
  logic        pps_flag_i;
  logic [31:0] cur_sec_i;
  logic        ovr_clr_i;
  logic        txd_o;
  logic        busy_o;
  logic        overrun_o;
  logic [15:0] frame_count_o;

  int          n_cmp = 0;
  int          n_err = 0;
  int          mon_frames = 0;
  logic [31:0] exp_q[$];

  always #5 sys_clk_i = ~sys_clk_i;

  pps_time_tx #(.BIT_DIV(BD)) dut (
    .sys_clk_i    (sys_clk_i),
    .sys_rst_n_i  (sys_rst_n_i),
    .en_i         (en_i),
    .pps_flag_i   (pps_flag_i),
    .cur_sec_i    (cur_sec_i),
    .ovr_clr_i    (ovr_clr_i),
    .txd_o        (txd_o),
    .busy_o       (busy_o),
    .overrun_o    (overrun_o),
    .frame_count_o(frame_count_o)
  );

  // Expected line level i cycles after the start edge.
  function automatic logic exp_bit(input logic [31:0] s, input int i);
    int b;
    b = i / BD;
    if (b == 0) return 1'b0;
    if (b <= 32) return s[b-1];
    if (b == 33) return ^s;
    return 1'b1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk_i);
  endtask

  // Frame monitor / scoreboard consumer.
  initial begin : monitor
    logic [34:0] bits;
    logic [31:0] e;
    bit          hold_ok;
    bit          aborted;
    forever begin
      @(negedge sys_clk_i);
      if (sys_rst_n_i === 1'b1 && txd_o === 1'b0) begin
        bits    = '0;
        hold_ok = 1'b1;
        aborted = 1'b0;
        for (int i = 0; i < FL; i++) begin
          if (i > 0) @(negedge sys_clk_i);
          if (sys_rst_n_i !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (i % BD == 0) bits[i/BD] = txd_o;
          else if (txd_o !== bits[i/BD]) hold_ok = 1'b0;
        end
        if (!aborted) begin
          mon_frames++;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected_frame: got frame bits %h, required no frame", bits);
          end else begin
            e = exp_q.pop_front();
            if (bits !== {1'b1, ^e, e, 1'b0} || !hold_ok) begin
              n_err++;
              $display("FAIL sb_frame: got bits %h hold_ok %0d, required bits %h hold_ok 1",
                       bits, hold_ok, {1'b1, ^e, e, 1'b0});
            end
          end
        end
      end
    end
  end

  // Drives one PPS at the current negedge and follows the frame cycle by
  // cycle. Optional mid-frame events fire at frame cycle index *_at.
  task automatic run_frame(input logic [31:0] sec, input int coll_at, input int clr_at,
                           input int en_off_at, output int bad, output int first_bad,
                           output logic [31:0] word, output logic par,
                           output logic ovr_coll, output logic ovr_clr);
    int b;
    bad = 0; first_bad = -1; word = '0; par = 1'bx; ovr_coll = 1'bx; ovr_clr = 1'bx;
    pps_flag_i = 1'b1;
    cur_sec_i  = sec;
    exp_q.push_back(sec);
    @(negedge sys_clk_i);
    pps_flag_i = 1'b0;
    cur_sec_i  = ~sec;
    for (int i = 0; i < FL; i++) begin
      if (txd_o !== exp_bit(sec, i) || busy_o !== 1'b1) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      if (i % BD == BD / 2) begin
        b = i / BD;
        if (b >= 1 && b <= 32) word[b-1] = txd_o;
        else if (b == 33) par = txd_o;
      end
      if (i == coll_at + 1) ovr_coll = overrun_o;
      if (i == clr_at + 1) ovr_clr = overrun_o;
      if (i == coll_at) begin
        pps_flag_i = 1'b1;
        cur_sec_i  = $urandom;
      end
      if (i == clr_at) ovr_clr_i = 1'b1;
      if (i == en_off_at) en_i = 1'b0;
      @(negedge sys_clk_i);
      pps_flag_i = 1'b0;
      ovr_clr_i  = 1'b0;
    end
  endtask

  task automatic test_reset();
    sys_rst_n_i = 1'b0;
    en_i = 1'b0; pps_flag_i = 1'b0; cur_sec_i = '0; ovr_clr_i = 1'b0;
    tick(3);
    n_cmp++; if (txd_o !== 1'b1) begin n_err++; $display("FAIL rst_txd: got %b, required 1", txd_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b, required 0", busy_o); end
    n_cmp++; if (overrun_o !== 1'b0) begin n_err++; $display("FAIL rst_ovr: got %b, required 0", overrun_o); end
    n_cmp++; if (frame_count_o !== 16'd0) begin n_err++; $display("FAIL rst_cnt: got %h, required 0000", frame_count_o); end
    sys_rst_n_i = 1'b1;
    tick(2);
  endtask

  task automatic test_basic();
    int bad, fb; logic [31:0] w; logic p, oc, ol;
    en_i = 1'b1;
    tick(8);
    run_frame(32'h0000_0001, -1, -1, -1, bad, fb, w, p, oc, ol);
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL basic_wave: got %0d bad cycles (first %0d), required 0", bad, fb); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL basic_busy_end: got %b, required 0", busy_o); end
    n_cmp++; if (txd_o !== 1'b1) begin n_err++; $display("FAIL basic_idle_txd: got %b, required 1", txd_o); end
    n_cmp++; if (frame_count_o !== 16'd1) begin n_err++; $display("FAIL basic_cnt: got %h, required 0001", frame_count_o); end
  endtask

  task automatic test_pattern();
    int bad, fb; logic [31:0] w; logic p, oc, ol;
    tick(3);
    run_frame(32'hA5A5_A5A5, -1, -1, -1, bad, fb, w, p, oc, ol);
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL pat_wave: got %0d bad cycles (first %0d), required 0", bad, fb); end
    n_cmp++; if (w !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL pat_word: got %h, required a5a5a5a5", w); end
    n_cmp++; if (p !== 1'b0) begin n_err++; $display("FAIL pat_parity: got %b, required 0", p); end
    n_cmp++; if (frame_count_o !== 16'd2) begin n_err++; $display("FAIL pat_cnt: got %h, required 0002", frame_count_o); end
  endtask

  task automatic test_collision();
    int bad, fb, mf0; logic [31:0] w; logic p, oc, ol;
    tick(3);
    mf0 = mon_frames;
    run_frame(32'h1357_9BDF, 39, 50, -1, bad, fb, w, p, oc, ol);
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL coll_wave: got %0d bad cycles (first %0d), required 0", bad, fb); end
    n_cmp++; if (oc !== 1'b1) begin n_err++; $display("FAIL coll_ovr_set: got %b, required 1", oc); end
    n_cmp++; if (ol !== 1'b0) begin n_err++; $display("FAIL coll_ovr_clr: got %b, required 0", ol); end
    tick(6);
    n_cmp++; if (mon_frames != mf0 + 1) begin n_err++; $display("FAIL coll_frames: got %0d, required %0d", mon_frames, mf0 + 1); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL coll_no_2nd: got busy %b, required 0", busy_o); end
    run_frame(32'h0F0F_00FF, 80, 80, -1, bad, fb, w, p, oc, ol);
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL coll2_wave: got %0d bad cycles (first %0d), required 0", bad, fb); end
    n_cmp++; if (ol !== 1'b1) begin n_err++; $display("FAIL coll_set_wins: got %b, required 1", ol); end
    tick(2);
    ovr_clr_i = 1'b1;
    tick(1);
    ovr_clr_i = 1'b0;
    n_cmp++; if (overrun_o !== 1'b0) begin n_err++; $display("FAIL coll_idle_clr: got %b, required 0", overrun_o); end
    n_cmp++; if (frame_count_o !== 16'd4) begin n_err++; $display("FAIL coll_cnt: got %h, required 0004", frame_count_o); end
  endtask

  task automatic test_enable();
    int bad, fb, mf0, idle_bad; logic [31:0] w; logic p, oc, ol;
    mf0 = mon_frames;
    en_i = 1'b0;
    tick(2);
    pps_flag_i = 1'b1; cur_sec_i = 32'h7777_7777;
    tick(1);
    pps_flag_i = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (txd_o !== 1'b1 || busy_o !== 1'b0) idle_bad++;
      tick(1);
    end
    n_cmp++; if (idle_bad != 0) begin n_err++; $display("FAIL en_off_idle: got %0d active cycles, required 0", idle_bad); end
    n_cmp++; if (overrun_o !== 1'b0) begin n_err++; $display("FAIL en_off_ovr: got %b, required 0", overrun_o); end
    en_i = 1'b1;
    run_frame(32'h0BAD_F00D, -1, -1, 20, bad, fb, w, p, oc, ol);
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL en_drop_wave: got %0d bad cycles (first %0d), required 0", bad, fb); end
    n_cmp++; if (frame_count_o !== 16'd5) begin n_err++; $display("FAIL en_drop_cnt: got %h, required 0005", frame_count_o); end
    tick(2);
    pps_flag_i = 1'b1; cur_sec_i = 32'h1234_0000;
    tick(1);
    pps_flag_i = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (txd_o !== 1'b1 || busy_o !== 1'b0) idle_bad++;
      tick(1);
    end
    n_cmp++; if (idle_bad != 0) begin n_err++; $display("FAIL en_later_idle: got %0d active cycles, required 0", idle_bad); end
    n_cmp++; if (mon_frames != mf0 + 1) begin n_err++; $display("FAIL en_frames: got %0d, required %0d", mon_frames, mf0 + 1); end
    n_cmp++; if (frame_count_o !== 16'd5) begin n_err++; $display("FAIL en_later_cnt: got %h, required 0005", frame_count_o); end
  endtask

  task automatic test_reset_mid();
    int bad, fb; logic [31:0] w; logic p, oc, ol;
    en_i = 1'b1;
    tick(2);
    pps_flag_i = 1'b1; cur_sec_i = 32'h1234_5678;
    tick(1);
    pps_flag_i = 1'b0;
    tick(11 * BD + 1);
    #2 sys_rst_n_i = 1'b0;
    #1;
    n_cmp++; if (txd_o !== 1'b1) begin n_err++; $display("FAIL rmid_txd: got %b, required 1", txd_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b, required 0", busy_o); end
    n_cmp++; if (frame_count_o !== 16'd0) begin n_err++; $display("FAIL rmid_cnt: got %h, required 0000", frame_count_o); end
    tick(3);
    sys_rst_n_i = 1'b1;
    tick(2);
    run_frame(32'hDEAD_BEEF, -1, -1, -1, bad, fb, w, p, oc, ol);
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL rmid_wave: got %0d bad cycles (first %0d), required 0", bad, fb); end
    n_cmp++; if (w !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rmid_word: got %h, required deadbeef", w); end
    n_cmp++; if (frame_count_o !== 16'd1) begin n_err++; $display("FAIL rmid_cnt_after: got %h, required 0001", frame_count_o); end
  endtask

  task automatic test_back_to_back();
    int bad, fb; logic [31:0] w; logic p, oc, ol;
    tick(2);
    run_frame(32'h1111_1111, -1, -1, -1, bad, fb, w, p, oc, ol);
    run_frame(32'h2222_2222, -1, -1, -1, bad, fb, w, p, oc, ol);
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL b2b_wave: got %0d bad cycles (first %0d), required 0", bad, fb); end
    n_cmp++; if (overrun_o !== 1'b0) begin n_err++; $display("FAIL b2b_ovr: got %b, required 0", overrun_o); end
    n_cmp++; if (frame_count_o !== 16'd3) begin n_err++; $display("FAIL b2b_cnt: got %h, required 0003", frame_count_o); end
    tick(2);
    force dut.frame_cnt_q = 16'hFFFF;
    tick(2);
    release dut.frame_cnt_q;
    tick(1);
    n_cmp++; if (frame_count_o !== 16'hFFFF) begin n_err++; $display("FAIL wrap_pre: got %h, required ffff", frame_count_o); end
    run_frame(32'h0000_0005, -1, -1, -1, bad, fb, w, p, oc, ol);
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL wrap_wave: got %0d bad cycles (first %0d), required 0", bad, fb); end
    n_cmp++; if (frame_count_o !== 16'h0000) begin n_err++; $display("FAIL wrap_cnt: got %h, required 0000", frame_count_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pattern();
    test_collision();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    tick(5);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d undelivered frames, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
